// File: rtl/ps2_pkg.sv
// Shared PS/2 decode definitions: protocol byte values, decoder state type, event record.
// Purely declarative; no timing or flow control of its own.
// The decoder state type shrinks to IDLE/BRK unless PS2_KEY_DECODER_EXT_EN is defined.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_BAT    = 8'hAA;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RESEND = 8'hFE;

`ifdef PS2_KEY_DECODER_EXT_EN
    typedef enum logic [1:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK
    } ps2_state_t;
`else
    typedef enum logic {
        IDLE,
        BRK
    } ps2_state_t;
`endif

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_evt_t;

    // Keyboard housekeeping replies that carry no key information.
    function automatic logic is_housekeeping(input logic [7:0] b);
        return (b == PS2_BAT) || (b == PS2_ACK) || (b == PS2_RESEND);
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Generic valid/ready FIFO with a registered head output and explicit full flag.
// Latency: a write into an empty FIFO is visible at rd_dat/rd_vld the next cycle.
// Backpressure: wr_rdy drops when full unless a read frees a slot in the same cycle.
module ps2_evt_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             wr_rdy,
    output logic             rd_vld,
    output logic [WIDTH-1:0] rd_dat,
    input  logic             rd_rdy
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             full_q, full_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             empty;
    logic             wr_ok;
    logic             rd_ok;
    logic             empty_next;

    assign empty  = (wr_ptr_q == rd_ptr_q) && !full_q;
    assign rd_ok  = rd_rdy && !empty;
    assign wr_rdy = !full_q || rd_ok;
    assign wr_ok  = wr_vld && wr_rdy;
    assign rd_vld = !empty;
    assign rd_dat = dout_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        full_d   = full_q;
        if (wr_ok) begin
            mem_d[wr_ptr_q] = wr_dat;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (wr_ok && !rd_ok) begin
            full_d = (wr_ptr_d == rd_ptr_q);
        end else if (rd_ok && !wr_ok) begin
            full_d = 1'b0;
        end
    end

    assign empty_next = (wr_ptr_d == rd_ptr_d) && !full_d;

    // The head register must see this cycle's write when that entry becomes the new head.
    always_comb begin
        dout_d = dout_q;
        if (wr_ok && (rd_ptr_d == wr_ptr_q)) begin
            dout_d = wr_dat;
        end else if (!empty_next) begin
            dout_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            dout_q   <= dout_d;
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan-code decoder: prefixes E0/F0 fold into press/release events queued in a FIFO.
// Latency: event on ev_* one cycle after the final byte strobe; held tracks HOLD_CODE likewise.
// Backpressure: ev_valid/ev_ready pop; events arriving at a full FIFO are dropped and set overflow.
// E0 (extended) support is built only with PS2_KEY_DECODER_EXT_EN defined.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [7:0]  HOLD_CODE  = 8'h24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_err,
    output logic [7:0] ev_code,
    output logic       ev_break,
    output logic       ev_ext,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic       held,
    output logic       overflow,
    input  logic       clr_overflow
);

    ps2_state_t state_q, state_d;
    logic       held_q, held_d;
    logic       overflow_q, overflow_d;
    ps2_evt_t   evt;
    logic       evt_vld;
    logic       fifo_wr_rdy;
    ps2_evt_t   head;
    logic       byte_ok;

`ifdef PS2_KEY_DECODER_EXT_EN
    assign byte_ok = rx_valid && !rx_err;
`else
    assign byte_ok = rx_valid && !rx_err && (rx_data != PS2_EXT);
`endif

    always_comb begin
        state_d  = state_q;
        evt_vld  = 1'b0;
        evt      = '0;
        evt.code = rx_data;
`ifdef PS2_KEY_DECODER_EXT_EN
        evt.brk  = (state_q == BRK) || (state_q == EXT_BRK);
        evt.ext  = (state_q == EXT) || (state_q == EXT_BRK);
`else
        evt.brk  = (state_q == BRK);
        evt.ext  = 1'b0;
`endif
        if (rx_valid && rx_err) begin
            state_d = IDLE;
        end else if (byte_ok) begin
            state_d = IDLE;
            case (state_q)
                IDLE: begin
                    if (rx_data == PS2_BRK) begin
                        state_d = BRK;
`ifdef PS2_KEY_DECODER_EXT_EN
                    end else if (rx_data == PS2_EXT) begin
                        state_d = EXT;
`endif
                    end else if (!is_housekeeping(rx_data)) begin
                        evt_vld = 1'b1;
                    end
                end
                // A repeated prefix is a protocol error: fall back to IDLE silently.
                BRK: begin
                    evt_vld = (rx_data != PS2_BRK);
                end
`ifdef PS2_KEY_DECODER_EXT_EN
                EXT: begin
                    if (rx_data == PS2_BRK) begin
                        state_d = EXT_BRK;
                    end else if (rx_data != PS2_EXT) begin
                        evt_vld = 1'b1;
                    end
                end
                EXT_BRK: begin
                    evt_vld = (rx_data != PS2_EXT) && (rx_data != PS2_BRK);
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    // held follows the decoded key stream, independent of whether the FIFO kept the event.
    always_comb begin
        held_d = held_q;
        if (evt_vld && (evt.code == HOLD_CODE) && !evt.ext) begin
            held_d = !evt.brk;
        end
    end

    assign overflow_d = (overflow_q && !clr_overflow) || (evt_vld && !fifo_wr_rdy);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            held_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            held_q     <= held_d;
            overflow_q <= overflow_d;
        end
    end

    ps2_evt_fifo #(
        .WIDTH ($bits(ps2_evt_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (evt_vld),
        .wr_dat (evt),
        .wr_rdy (fifo_wr_rdy),
        .rd_vld (ev_valid),
        .rd_dat (head),
        .rd_rdy (ev_ready)
    );

    // Without extended support the ext field is never written as 1, so ev_ext is constant 0.
    assign ev_code  = head.code;
    assign ev_break = head.brk;
    assign ev_ext   = head.ext;
    assign held     = held_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: queue-based event model checked every cycle plus literal pins.
module tb_ps2_key_decoder;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_err = 1'b0;
    logic       ev_ready = 1'b0;
    logic       clr_overflow = 1'b0;
    logic [7:0] ev_code;
    logic       ev_break;
    logic       ev_ext;
    logic       ev_valid;
    logic       held;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    ps2_key_decoder #(.FIFO_DEPTH(DEPTH), .HOLD_CODE(8'h24)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_err       (rx_err),
        .ev_code      (ev_code),
        .ev_break     (ev_break),
        .ev_ext       (ev_ext),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .held         (held),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Behavioural model: pending-prefix flags, a queue of events, held and overflow bits.
    typedef struct {
        logic [7:0] code;
        logic       brk;
        logic       ext;
    } mev_t;

    mev_t q[$];
    mev_t e;
    logic m_ext, m_brk, m_held, m_ovf, gen;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_ext = 1'b0; m_brk = 1'b0; m_held = 1'b0; m_ovf = 1'b0;
        end else begin
            gen = 1'b0;
            if (rx_valid && rx_err) begin
                m_ext = 1'b0; m_brk = 1'b0;
            end else if (rx_valid) begin
                if (rx_data == 8'hE0) begin
`ifdef PS2_KEY_DECODER_EXT_EN
                    if (m_ext) begin
                        m_ext = 1'b0; m_brk = 1'b0;
                    end else if (m_brk) begin
                        gen = 1'b1;
                    end else begin
                        m_ext = 1'b1;
                    end
`endif
                end else if (rx_data == 8'hF0) begin
                    if (m_brk) begin
                        m_ext = 1'b0; m_brk = 1'b0;
                    end else begin
                        m_brk = 1'b1;
                    end
                end else if (!m_ext && !m_brk &&
                             (rx_data == 8'hAA || rx_data == 8'hFA || rx_data == 8'hFE)) begin
                    gen = 1'b0;
                end else begin
                    gen = 1'b1;
                end
                if (gen) begin
                    e.code = rx_data; e.brk = m_brk; e.ext = m_ext;
                    m_ext = 1'b0; m_brk = 1'b0;
                end
            end
            if (ev_ready && q.size() > 0) void'(q.pop_front());
            if (clr_overflow) m_ovf = 1'b0;
            if (gen) begin
                if (e.code == 8'h24 && !e.ext) m_held = !e.brk;
                if (q.size() < DEPTH) q.push_back(e);
                else m_ovf = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        chk("m_valid", ev_valid, q.size() != 0);
        chk("m_held", held, m_held);
        chk("m_overflow", overflow, m_ovf);
        if (q.size() != 0) begin
            chk("m_code", ev_code, q[0].code);
            chk("m_break", ev_break, q[0].brk);
            chk("m_ext", ev_ext, q[0].ext);
        end
    end

    // Drives one cycle of inputs; entered and left #1 after a rising edge.
    task automatic send(input logic v, input logic [7:0] b, input logic er,
                        input logic pop, input logic clr);
        rx_valid = v; rx_data = b; rx_err = er; ev_ready = pop; clr_overflow = clr;
        @(posedge clk); #1;
        rx_valid = 1'b0; rx_err = 1'b0; ev_ready = 1'b0; clr_overflow = 1'b0;
    endtask

    task automatic key(input logic [7:0] b);
        send(1'b1, b, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        int n = 0;
        ev_ready = 1'b1;
        while (ev_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        ev_ready = 1'b0;
        chk("drain_empty", ev_valid, 1'b0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, ev_valid, 1'b0);
        chk({tag, "_held"}, held, 1'b0);
        chk({tag, "_overflow"}, overflow, 1'b0);
        chk({tag, "_code"}, ev_code, 8'h00);
        chk({tag, "_break"}, ev_break, 1'b0);
        chk({tag, "_ext"}, ev_ext, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Single make code, latency of one cycle.
        chk("pre_1c_valid", ev_valid, 1'b0);
        key(8'h1C);
        chk("1c_valid", ev_valid, 1'b1);
        chk("1c_code", ev_code, 8'h1C);
        chk("1c_break", ev_break, 1'b0);
        chk("1c_ext", ev_ext, 1'b0);
        drain();

        // Housekeeping byte in IDLE produces nothing.
        key(8'hAA);
        key(8'hFA);
        chk("bat_ack_discard", ev_valid, 1'b0);

        // Extended release.
        key(8'hE0); key(8'hF0); key(8'h75);
        chk("e0f075_code", ev_code, 8'h75);
        chk("e0f075_break", ev_break, 1'b1);
`ifdef PS2_KEY_DECODER_EXT_EN
        chk("e0f075_ext", ev_ext, 1'b1);
`else
        chk("e0f075_ext", ev_ext, 1'b0);
`endif
        key(8'h1C);
        drain();

        // Held key tracking.
        key(8'h24);
        chk("held_set", held, 1'b1);
        key(8'hF0); key(8'h24);
        chk("held_clear", held, 1'b0);
        chk("held_head_code", ev_code, 8'h24);
        chk("held_head_break", ev_break, 1'b0);
        drain();

        // Overflow with a stalled consumer.
        key(8'h16); key(8'h1E); key(8'h26); key(8'h25); key(8'h2E);
        chk("ovf_set", overflow, 1'b1);
        chk("ovf_head", ev_code, 8'h16);
        send(1'b1, 8'h3D, 1'b0, 1'b0, 1'b1);
        chk("ovf_set_wins", overflow, 1'b1);
        send(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("ovf_cleared", overflow, 1'b0);
        send(1'b1, 8'h36, 1'b0, 1'b1, 1'b0);
        chk("full_push_pop_ovf", overflow, 1'b0);
        chk("full_push_pop_head", ev_code, 8'h1E);
        drain();

        // Errored break prefix is forgotten.
        send(1'b1, 8'hF0, 1'b1, 1'b0, 1'b0);
        key(8'h1C);
        chk("err_code", ev_code, 8'h1C);
        chk("err_break", ev_break, 1'b0);
        drain();

        // Reset in the middle of a release sequence.
        key(8'h24);
        key(8'hF0);
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        key(8'h1C);
        chk("post_rst_code", ev_code, 8'h1C);
        chk("post_rst_break", ev_break, 1'b0);
        drain();

        repeat (2) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
